sprite_compositor: RTL and testbench
====================================

// Module: sprite_compositor
// PURPOSE
//  Parametrised N-sprite pixel compositor for the 640x480 VGA path. Takes pixel coords/timing
//  from the VGA timing generator, holds per-sprite position/colour/visibility, and produces
//  registered 8-bit R/G/B with priority, screen border and per-frame collision flags.
//  Game logic writes sprite state any time; it takes effect only at frame boundaries (no tearing).
// PARAMETERS
//  NUM_SPRITES  4        number of sprites (1..8); index 0 = highest priority
//  SPR_W        10       sprite width in pixels (all sprites)
//  SPR_H        10       sprite height in pixels
//  H_ACTIVE     640      active pixels per line
//  V_ACTIVE     480      active lines per frame
//  BORDER       11       border thickness in pixels (0 = no border)
//  BORDER_RGB   24'h0000FF  border colour {R,G,B}
// PORTS
//  VGA_clk      in   1     25 MHz pixel clock
//  reset        in   1     synchronous, active-high
//  xCount       in   10    current pixel x
//  yCount       in   10    current pixel y
//  displayArea  in   1     active-video qualifier
//  hSync_in     in   1     h-sync from timing gen (active-low)
//  vSync_in     in   1     v-sync from timing gen (active-low)
//  blank_in     in   1     blank_n from timing gen
//  wr_en        in   1     write request for one sprite's shadow registers
//  wr_ready     out  1     write accepted on cycles where wr_en && wr_ready
//  wr_idx       in   3     sprite index; idx >= NUM_SPRITES is accepted and discarded
//  wr_x         in   10    sprite left edge
//  wr_y         in   9     sprite top edge
//  wr_visible   in   1     sprite enable
//  wr_rgb       in   24    sprite colour {R,G,B}
//  VGA_R/G/B    out  8 ea  pixel colour
//  VGA_hSync    out  1     h-sync delayed to match pixel latency
//  VGA_vSync    out  1     v-sync delayed to match pixel latency
//  blank_n      out  1     blank delayed to match pixel latency
//  collision    out  NUM_SPRITES  bit i = sprite i overlapped another visible sprite last frame
//  frame_done   out  1     1-cycle pulse when collision is updated
// BEHAVIOUR
//  Reset: all shadow/active regs 0 (all sprites invisible); VGA_R/G/B=0; VGA_hSync=VGA_vSync=1;
//   blank_n=0; collision=0; frame_done=0; wr_ready=0 while reset high, 1 the cycle after.
//  Swap cycle S: xCount==0 && yCount==V_ACTIVE. In S: active <= shadow for all sprites,
//   wr_ready=0 (no write accepted), collision <= accumulator, accumulator cleared.
//   frame_done=1 in cycle S+1 only. wr_ready=1 in every other non-reset cycle.
//  Writes: accepted write updates shadow[wr_idx] at next edge; last write before S wins.
//   Writes never alter the active set until the next S.
//  Hit test (stage 1, registered): hit[i] = visible[i] && x>=sx && x<sx+SPR_W && y>=sy &&
//   y<sy+SPR_H, sums computed 11 bits wide (no wrap; sprites past right/bottom edge clip).
//   border = x<BORDER || x>=H_ACTIVE-BORDER || y<BORDER || y>=V_ACTIVE-BORDER.
//  Mux (stage 2, registered): if !displayArea(delayed) -> 0; else lowest-index hit sprite colour;
//   else border colour if border; else 0 (black).
//  Latency: exactly 2 VGA_clk from xCount/yCount to VGA_R/G/B; hSync/vSync/blank pass through the
//   same 2-stage delay so alignment is preserved.
//  Collision accumulator: in stage 2 with displayArea, if >=2 hit bits set, OR those bits in.
//   Only active-area pixels count. If S coincides with stage-2 pixel, that pixel counts in the new frame (none exist: S is blanking).
//  Reset mid-frame: pipeline and flags cleared; first swap after reset loads current shadow.
// STRUCTURE
//  Package vga_sprite_pkg: H_ACTIVE, V_ACTIVE, coord widths, rgb_t (24-bit) and sprite_t
//   {x,y,visible,rgb} typedef.
//  Sub-module sprite_hit: one instance per sprite (generate), registered stage-1 hit for one sprite.
//  Top holds shadow/active arrays, write handshake, swap, priority mux, sync delay, collision.
// TESTING
//  Reset then idle frame: all outputs at reset values; after reset, only border pixels = 0000FF, rest 0.
//  Write idx0 x=100 y=50 rgb=FF0000 mid-frame -> no change until S; next frame pixels x100..109,
//   y50..59 red, appearing 2 cycles after matching xCount/yCount.
//  Sprites 0 (green) and 2 (red) overlapping at (200,200) -> overlap shows green; after S
//   collision=3'b101-pattern (bits 0,2), frame_done pulses once at S+1.
//  wr_en held high across S -> wr_ready=0 in S, write accepted at S+1, visible only the frame after.
//  Sprite at x=635,y=475 -> drawn x635..639/y475..479 only, no wrap to x=0/y=0; wr_idx=7 with NUM_SPRITES=4 -> no effect.
//  Reset asserted mid-frame for 1 cycle -> outputs return to reset values next cycle, sprites invisible.

Source files
------------

// File: rtl/vga_sprite_pkg.sv
// Sprite compositor shared types.
// Screen geometry, coordinate widths and sprite record.
package vga_sprite_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int SYW = 9;
  localparam int IDXW = 3;

  typedef logic [23:0] rgb_t;

  typedef struct packed {
    logic [XW-1:0]  x;
    logic [SYW-1:0] y;
    logic           visible;
    rgb_t           rgb;
  } sprite_t;
endpackage

// File: rtl/sprite_compositor_if.sv
// Sprite write bus between game logic and compositor.
// One sprite record per accepted beat.
interface sprite_compositor_if;
  import vga_sprite_pkg::*;

  logic            wr_en;
  logic            wr_ready;
  logic [IDXW-1:0] wr_idx;
  logic [XW-1:0]   wr_x;
  logic [SYW-1:0]  wr_y;
  logic            wr_visible;
  rgb_t            wr_rgb;

  modport master (
    output wr_en, wr_idx, wr_x, wr_y,
    output wr_visible, wr_rgb,
    input  wr_ready
  );

  modport slave (
    input  wr_en, wr_idx, wr_x, wr_y,
    input  wr_visible, wr_rgb,
    output wr_ready
  );
endinterface

// File: rtl/sprite_hit.sv
// Registered hit test for one sprite.
// Bounds are 11 bits wide so edge sprites clip.
module sprite_hit
  import vga_sprite_pkg::*;
#(
  parameter int SPR_W = 10,
  parameter int SPR_H = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [XW-1:0]  i_x,
  input  logic [YW-1:0]  i_y,
  input  logic [XW-1:0]  i_sx,
  input  logic [SYW-1:0] i_sy,
  input  logic           i_vis,
  output logic           o_hit
);
  localparam logic [10:0] L_W = 11'(SPR_W);
  localparam logic [10:0] L_H = 11'(SPR_H);

  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [10:0] w_sx;
  logic [10:0] w_sy;
  logic        w_hit;

  assign w_x  = {1'b0, i_x};
  assign w_y  = {1'b0, i_y};
  assign w_sx = {1'b0, i_sx};
  assign w_sy = {2'b0, i_sy};

  assign w_hit = i_vis
    && (w_x >= w_sx) && (w_x < w_sx + L_W)
    && (w_y >= w_sy) && (w_y < w_sy + L_H);

  // stage-1 hit register
  always_ff @(posedge clk) begin
    if (rst) o_hit <= 1'b0;
    else     o_hit <= w_hit;
  end
endmodule

// File: rtl/sprite_compositor.sv
// N-sprite compositor with border and collision flags.
// Sprite state is double-buffered and swapped in vblank.
module sprite_compositor
  import vga_sprite_pkg::*;
#(
  parameter int   NUM_SPRITES = 4,
  parameter int   SPR_W       = 10,
  parameter int   SPR_H       = 10,
  parameter int   H_ACTIVE    = vga_sprite_pkg::H_ACTIVE,
  parameter int   V_ACTIVE    = vga_sprite_pkg::V_ACTIVE,
  parameter int   BORDER      = 11,
  parameter rgb_t BORDER_RGB  = 24'h0000FF
) (
  input  logic                   VGA_clk,
  input  logic                   reset,
  input  logic [XW-1:0]          xCount,
  input  logic [YW-1:0]          yCount,
  input  logic                   displayArea,
  input  logic                   hSync_in,
  input  logic                   vSync_in,
  input  logic                   blank_in,
  sprite_compositor_if.slave     wr,
  output logic [7:0]             VGA_R,
  output logic [7:0]             VGA_G,
  output logic [7:0]             VGA_B,
  output logic                   VGA_hSync,
  output logic                   VGA_vSync,
  output logic                   blank_n,
  output logic [NUM_SPRITES-1:0] collision,
  output logic                   frame_done
);
  localparam logic [10:0] L_BL  = 11'(BORDER);
  localparam logic [10:0] L_BR  = 11'(H_ACTIVE - BORDER);
  localparam logic [10:0] L_BB  = 11'(V_ACTIVE - BORDER);
  localparam logic [YW-1:0] L_SY = YW'(V_ACTIVE);
  localparam logic [NUM_SPRITES-1:0] L_ONE = 1;

  sprite_t r_shadow [NUM_SPRITES];
  sprite_t r_active [NUM_SPRITES];

  logic [NUM_SPRITES-1:0] w_hit;
  logic [NUM_SPRITES-1:0] r_acc;
  logic r_border;
  logic r_de;
  logic r_hs;
  logic r_vs;
  logic r_bl;
  logic w_swap;
  logic w_wr;
  logic w_border;
  logic w_multi;
  rgb_t w_rgb;

  assign w_swap = (xCount == '0) && (yCount == L_SY);
  assign wr.wr_ready = !reset && !w_swap;
  assign w_wr = wr.wr_en && wr.wr_ready;

  assign w_border = ({1'b0, xCount} < L_BL)
    || ({1'b0, xCount} >= L_BR)
    || ({1'b0, yCount} < L_BL)
    || ({1'b0, yCount} >= L_BB);

  // shadow writes and frame-boundary swap
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (w_wr && wr.wr_idx == IDXW'(i))
          r_shadow[i] <= '{x: wr.wr_x, y: wr.wr_y,
            visible: wr.wr_visible, rgb: wr.wr_rgb};
        if (w_swap)
          r_active[i] <= r_shadow[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit #(
      .SPR_W(SPR_W),
      .SPR_H(SPR_H)
    ) u_hit (
      .clk  (VGA_clk),
      .rst  (reset),
      .i_x  (xCount),
      .i_y  (yCount),
      .i_sx (r_active[g].x),
      .i_sy (r_active[g].y),
      .i_vis(r_active[g].visible),
      .o_hit(w_hit[g])
    );
  end

  // stage 1: border flag and timing delay
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      r_border <= 1'b0;
      r_de     <= 1'b0;
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
      r_bl     <= 1'b0;
    end else begin
      r_border <= w_border;
      r_de     <= displayArea;
      r_hs     <= hSync_in;
      r_vs     <= vSync_in;
      r_bl     <= blank_in;
    end
  end

  // priority mux: lowest index wins over border
  always_comb begin
    w_rgb = '0;
    if (r_border) w_rgb = BORDER_RGB;
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      if (w_hit[i]) w_rgb = r_active[i].rgb;
    if (!r_de) w_rgb = '0;
  end

  // stage 2: output pixel and timing
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      VGA_hSync <= 1'b1;
      VGA_vSync <= 1'b1;
      blank_n   <= 1'b0;
    end else begin
      VGA_R     <= w_rgb[23:16];
      VGA_G     <= w_rgb[15:8];
      VGA_B     <= w_rgb[7:0];
      VGA_hSync <= r_hs;
      VGA_vSync <= r_vs;
      blank_n   <= r_bl;
    end
  end

  assign w_multi = r_de && ((w_hit & (w_hit - L_ONE)) != '0);

  // collision accumulate, publish at swap
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      r_acc      <= '0;
      collision  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_swap;
      if (w_swap) begin
        collision <= r_acc;
        r_acc     <= w_multi ? w_hit : '0;
      end else if (w_multi) begin
        r_acc <= r_acc | w_hit;
      end
    end
  end
endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor.
// Directed pixels, expected values queued by driver.
module tb_sprite_compositor;
  import vga_sprite_pkg::*;

  localparam rgb_t BRGB = 24'h0000FF;
  localparam rgb_t RED  = 24'hFF0000;
  localparam rgb_t GRN  = 24'h00FF00;
  localparam rgb_t WHT  = 24'hFFFFFF;
  localparam rgb_t BLU2 = 24'h0000F0;

  logic clk = 1'b0;
  logic reset;
  logic [9:0] xc;
  logic [9:0] yc;
  logic de, hs_i, vs_i, bl_i;
  logic [7:0] vr, vg, vb;
  logic hs_o, vs_o, bl_o;
  logic [3:0] coll;
  logic fd;

  sprite_compositor_if wif ();

  sprite_compositor dut (
    .VGA_clk    (clk),
    .reset      (reset),
    .xCount     (xc),
    .yCount     (yc),
    .displayArea(de),
    .hSync_in   (hs_i),
    .vSync_in   (vs_i),
    .blank_in   (bl_i),
    .wr         (wif),
    .VGA_R      (vr),
    .VGA_G      (vg),
    .VGA_B      (vb),
    .VGA_hSync  (hs_o),
    .VGA_vSync  (vs_o),
    .blank_n    (bl_o),
    .collision  (coll),
    .frame_done (fd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [23:0] rgb;
    logic [2:0]  sync;
  } px_t;

  typedef struct {
    int         due;
    logic [3:0] coll;
  } ev_t;

  px_t pq[$];
  ev_t eq[$];
  px_t pm;
  ev_t em;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic px(input int x, input int y, input bit d,
                    input rgb_t e, input bit rs = 1'b0);
    px_t it;
    xc = 10'(x);
    yc = 10'(y);
    de = d;
    hs_i = x[0];
    vs_i = y[0];
    bl_i = d;
    it.due = cyc + 2;
    it.rgb = rs ? 24'h0 : e;
    it.sync = rs ? 3'b110 : {x[0], y[0], d};
    pq.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic swap(input logic [3:0] c);
    px_t it;
    ev_t ev;
    xc = 10'd0;
    yc = 10'd480;
    de = 1'b0;
    hs_i = 1'b0;
    vs_i = 1'b0;
    bl_i = 1'b0;
    it.due = cyc + 2;
    it.rgb = 24'h0;
    it.sync = 3'b000;
    pq.push_back(it);
    ev.due = cyc + 1;
    ev.coll = c;
    eq.push_back(ev);
    #1 chk("wr_ready_in_swap", 32'(wif.wr_ready), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wr_set(input int idx, input int x, input int y,
                        input bit v, input rgb_t c);
    wif.wr_en = 1'b1;
    wif.wr_idx = 3'(idx);
    wif.wr_x = 10'(x);
    wif.wr_y = 9'(y);
    wif.wr_visible = v;
    wif.wr_rgb = c;
  endtask

  // monitor: compare whatever is due this cycle
  always @(negedge clk) begin
    if (cyc >= 2) begin
      while (pq.size() > 0 && pq[0].due < cyc) begin
        pm = pq.pop_front();
        chk("pixel_missed", 32'(pm.due), 32'(cyc));
      end
      if (pq.size() > 0 && pq[0].due == cyc) begin
        pm = pq.pop_front();
        chk("rgb", 32'({vr, vg, vb}), 32'(pm.rgb));
        chk("sync", 32'({hs_o, vs_o, bl_o}), 32'(pm.sync));
      end
      if (eq.size() > 0 && eq[0].due == cyc) begin
        em = eq.pop_front();
        chk("frame_done", 32'(fd), 1);
        chk("collision", 32'(coll), 32'(em.coll));
      end else begin
        chk("frame_done_idle", 32'(fd), 0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    wif.wr_en = 1'b0;
    wif.wr_idx = '0;
    wif.wr_x = '0;
    wif.wr_y = '0;
    wif.wr_visible = 1'b0;
    wif.wr_rgb = '0;
    xc = '0;
    yc = '0;
    de = 1'b0;
    hs_i = 1'b1;
    vs_i = 1'b1;
    bl_i = 1'b0;
    @(posedge clk);
    #1;
    px(5, 5, 1, 24'h0, 1);
    chk("wr_ready_rst", 32'(wif.wr_ready), 0);
    chk("collision_rst", 32'(coll), 0);
    px(6, 5, 1, 24'h0, 1);
    px(7, 5, 1, 24'h0, 1);
    reset = 1'b0;
    #1 chk("wr_ready_after_rst", 32'(wif.wr_ready), 1);

    px(5, 5, 1, BRGB);
    px(100, 100, 1, 24'h0);
    px(639, 479, 1, BRGB);
    px(629, 300, 1, BRGB);
    px(628, 300, 1, 24'h0);
    px(11, 11, 1, 24'h0);
    px(10, 200, 1, BRGB);
    px(300, 468, 1, 24'h0);
    px(300, 469, 1, BRGB);
    px(100, 100, 0, 24'h0);
    px(5, 5, 0, 24'h0);

    wr_set(0, 100, 50, 1, RED);
    px(300, 300, 1, 24'h0);
    wif.wr_en = 1'b0;
    px(100, 50, 1, 24'h0);
    swap(4'b0000);
    px(100, 50, 1, RED);
    px(109, 59, 1, RED);
    px(110, 50, 1, 24'h0);
    px(99, 50, 1, 24'h0);
    px(100, 60, 1, 24'h0);
    px(109, 49, 1, 24'h0);

    wr_set(0, 50, 400, 1, WHT);
    px(300, 300, 1, 24'h0);
    wr_set(0, 200, 200, 1, GRN);
    px(300, 301, 1, 24'h0);
    wr_set(2, 205, 205, 1, RED);
    px(300, 302, 1, 24'h0);
    wif.wr_en = 1'b0;
    px(207, 207, 1, 24'h0);
    swap(4'b0000);
    px(207, 207, 1, GRN);
    px(212, 212, 1, RED);
    px(202, 202, 1, GRN);
    px(100, 50, 1, 24'h0);
    px(52, 402, 1, 24'h0);
    px(207, 207, 0, 24'h0);
    swap(4'b0101);
    px(212, 212, 1, RED);
    swap(4'b0000);

    wr_set(1, 300, 300, 1, BLU2);
    swap(4'b0000);
    xc = 10'd1;
    #1 chk("wr_ready_after_swap", 32'(wif.wr_ready), 1);
    px(1, 480, 0, 24'h0);
    wif.wr_en = 1'b0;
    px(300, 300, 1, 24'h0);
    px(305, 305, 1, 24'h0);
    swap(4'b0000);
    px(300, 300, 1, BLU2);
    px(309, 309, 1, BLU2);

    wr_set(3, 635, 475, 1, WHT);
    px(320, 240, 1, 24'h0);
    wr_set(7, 100, 100, 1, 24'h123456);
    px(321, 240, 1, 24'h0);
    wif.wr_en = 1'b0;
    swap(4'b0000);
    px(635, 475, 1, WHT);
    px(639, 479, 1, WHT);
    px(634, 475, 1, BRGB);
    px(635, 474, 1, BRGB);
    px(0, 0, 1, BRGB);
    px(4, 4, 1, BRGB);
    px(100, 100, 1, 24'h0);
    px(300, 300, 1, BLU2);

    px(207, 207, 1, 24'h0, 1);
    reset = 1'b1;
    px(207, 207, 1, 24'h0, 1);
    chk("wr_ready_mid_rst", 32'(wif.wr_ready), 0);
    chk("collision_mid_rst", 32'(coll), 0);
    reset = 1'b0;
    #1 chk("wr_ready_post_rst", 32'(wif.wr_ready), 1);
    px(207, 207, 1, 24'h0);
    px(5, 5, 1, BRGB);
    swap(4'b0000);
    px(207, 207, 1, 24'h0);
    px(635, 475, 1, BRGB);

    for (int i = 0; i < 10; i++) begin
      if (pq.size() > 0 || eq.size() > 0) @(posedge clk);
    end
    #1;
    if (pq.size() > 0 || eq.size() > 0)
      chk("queue_drain", 32'(pq.size() + eq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
